// File: rtl/key_sweep_ctrl.sv
// key_sweep_ctrl
//   Brute-force key sweeper for the c432 golden/locked netlist pair.
//   For every key 0..2^KEY_W-1 the same NPAT-long LFSR pattern sequence is
//   driven on pat_out, the netlist outputs are compared after SETTLE cycles,
//   and the number of mismatching patterns per key is counted. Keys with a
//   zero mismatch count are reported as correct.
//
//   Optional build macro: KEY_SWEEP_EARLY_STOP_EN
//     defined   : the sweep ends at the first key with zero mismatches.
//     undefined : every key is always swept (default).
module key_sweep_ctrl #(
  parameter int              IN_W      = 36,
  parameter int              OUT_W     = 7,
  parameter int              KEY_W     = 3,
  parameter int              NPAT      = 16,
  parameter int              SETTLE    = 1,
  parameter logic [IN_W-1:0] LFSR_SEED = 36'hAAAAAAAAA,
  parameter logic [IN_W-1:0] LFSR_TAPS = 36'h800000800
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [IN_W-1:0]             pat_out,
  output logic [KEY_W-1:0]            key_out,
  input  logic [OUT_W-1:0]            gold_in,
  input  logic [OUT_W-1:0]            lock_in,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic [KEY_W-1:0]            found_key,
  output logic [KEY_W:0]              pass_count,
  output logic [$clog2(NPAT+1)-1:0]   mm_count
);

  localparam int CNT_W = $clog2(NPAT + 1);
  localparam int IDX_W = (NPAT > 1) ? $clog2(NPAT) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CMP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Even parity of a pattern-wide vector (LFSR feedback bit).
  function automatic logic parity_of(input logic [IN_W-1:0] vec);
    parity_of = ^vec;
  endfunction

  // Fibonacci LFSR step: shift left, feedback enters at bit 0.
  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] cur);
    lfsr_step = {cur[IN_W-2:0], parity_of(cur & LFSR_TAPS)};
  endfunction

  state_t             state_r, state_nxt_s;
  logic [IN_W-1:0]    pat_r, pat_nxt_s;
  logic [KEY_W-1:0]   key_r, key_nxt_s;
  logic [SET_W-1:0]   settle_r, settle_nxt_s;
  logic [IDX_W-1:0]   idx_r, idx_nxt_s;
  logic [CNT_W-1:0]   mm_cnt_r, mm_cnt_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
  logic               found_r, found_nxt_s;
  logic [KEY_W-1:0]   found_key_r, found_key_nxt_s;
  logic [KEY_W:0]     pass_r, pass_nxt_s;
  logic [CNT_W-1:0]   mm_count_r, mm_count_nxt_s;

  logic               mismatch_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               key_pass_s;
  logic               last_key_s;
  logic               last_pat_s;
  logic               stop_s;

  // Next-state and next-value logic for the sweep FSM and its datapath.
  always_comb begin
    state_nxt_s     = state_r;
    pat_nxt_s       = pat_r;
    key_nxt_s       = key_r;
    settle_nxt_s    = settle_r;
    idx_nxt_s       = idx_r;
    mm_cnt_nxt_s    = mm_cnt_r;
    found_nxt_s     = found_r;
    found_key_nxt_s = found_key_r;
    pass_nxt_s      = pass_r;
    mm_count_nxt_s  = mm_count_r;

    mismatch_s = |(gold_in ^ lock_in);
    cnt_inc_s  = mm_cnt_r + CNT_W'(mismatch_s);
    key_pass_s = (cnt_inc_s == {CNT_W{1'b0}});
    last_key_s = (key_r == {KEY_W{1'b1}});
    last_pat_s = !(idx_r < IDX_W'(NPAT - 1));
`ifdef KEY_SWEEP_EARLY_STOP_EN
    // The first passing key ends the sweep; found_r is still clear then.
    stop_s = last_key_s || key_pass_s;
`else
    stop_s = last_key_s;
`endif

    case (state_r)
      S_IDLE: begin
        if (start) begin
          key_nxt_s       = {KEY_W{1'b0}};
          pat_nxt_s       = LFSR_SEED;
          settle_nxt_s    = SET_W'(SETTLE - 1);
          idx_nxt_s       = {IDX_W{1'b0}};
          mm_cnt_nxt_s    = {CNT_W{1'b0}};
          found_nxt_s     = 1'b0;
          found_key_nxt_s = {KEY_W{1'b0}};
          pass_nxt_s      = {(KEY_W+1){1'b0}};
          mm_count_nxt_s  = {CNT_W{1'b0}};
          state_nxt_s     = S_APPLY;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end

      S_APPLY: begin
        if (settle_r == {SET_W{1'b0}}) begin
          state_nxt_s = S_CMP;
        end else begin
          settle_nxt_s = settle_r - SET_W'(1'b1);
        end
      end

      S_CMP: begin
        if (!last_pat_s) begin
          // More patterns for this key.
          mm_cnt_nxt_s = cnt_inc_s;
          pat_nxt_s    = lfsr_step(pat_r);
          idx_nxt_s    = idx_r + IDX_W'(1'b1);
          settle_nxt_s = SET_W'(SETTLE - 1);
          state_nxt_s  = S_APPLY;
        end else begin
          // End of key: publish the count and score the key.
          mm_count_nxt_s = cnt_inc_s;
          if (key_pass_s) begin
            pass_nxt_s = pass_r + (KEY_W+1)'(1'b1);
            if (!found_r) begin
              found_nxt_s     = 1'b1;
              found_key_nxt_s = key_r;
            end else begin
              found_nxt_s     = found_r;
            end
          end else begin
            pass_nxt_s = pass_r;
          end
          if (stop_s) begin
            state_nxt_s = S_DONE;
          end else begin
            key_nxt_s    = key_r + KEY_W'(1'b1);
            pat_nxt_s    = LFSR_SEED;
            idx_nxt_s    = {IDX_W{1'b0}};
            mm_cnt_nxt_s = {CNT_W{1'b0}};
            settle_nxt_s = SET_W'(SETTLE - 1);
            state_nxt_s  = S_APPLY;
          end
        end
      end

      S_DONE: begin
        // start is deliberately not sampled here.
        state_nxt_s = S_IDLE;
      end

      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s != S_IDLE);
    done_nxt_s = (state_nxt_s == S_DONE);
  end

  // State and datapath registers; every output is driven from here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      pat_r       <= {IN_W{1'b0}};
      key_r       <= {KEY_W{1'b0}};
      settle_r    <= {SET_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      mm_cnt_r    <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      found_r     <= 1'b0;
      found_key_r <= {KEY_W{1'b0}};
      pass_r      <= {(KEY_W+1){1'b0}};
      mm_count_r  <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      pat_r       <= pat_nxt_s;
      key_r       <= key_nxt_s;
      settle_r    <= settle_nxt_s;
      idx_r       <= idx_nxt_s;
      mm_cnt_r    <= mm_cnt_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      found_r     <= found_nxt_s;
      found_key_r <= found_key_nxt_s;
      pass_r      <= pass_nxt_s;
      mm_count_r  <= mm_count_nxt_s;
    end
  end

  assign pat_out    = pat_r;
  assign key_out    = key_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign found      = found_r;
  assign found_key  = found_key_r;
  assign pass_count = pass_r;
  assign mm_count   = mm_count_r;

endmodule

// File: tb/tb_key_sweep_ctrl.sv
// Scoreboard bench for key_sweep_ctrl: stimulus pushes the expected sweep
// result, a monitor pops and compares it on every done pulse and also checks
// the pattern sequence applied to each key.
module tb_key_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [35:0] pat_out;
  logic [2:0]  key_out;
  logic [6:0]  gold_in;
  logic [6:0]  lock_in;
  logic        busy;
  logic        done;
  logic        found;
  logic [2:0]  found_key;
  logic [3:0]  pass_count;
  logic [4:0]  mm_count;

  int checks = 0;
  int errors = 0;
  int mode   = 0;

  typedef struct packed {
    logic        found;
    logic [2:0]  fk;
    logic [3:0]  pass;
    logic [4:0]  mm;
    logic [2:0]  key;
    logic [15:0] cycles;
  } exp_t;

  exp_t        sb[$];
  logic [35:0] exp_pat [16];

  key_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .pat_out(pat_out), .key_out(key_out),
    .gold_in(gold_in), .lock_in(lock_in),
    .busy(busy), .done(done), .found(found), .found_key(found_key),
    .pass_count(pass_count), .mm_count(mm_count)
  );

  always #5 clk = ~clk;

  // Netlist stand-ins: a golden function and a locked copy that depends on mode.
  always_comb begin
    gold_in = pat_out[6:0] ^ pat_out[13:7];
    case (mode)
      0:       lock_in = (key_out == 3'd0) ? gold_in : (gold_in ^ 7'h40);
      1:       lock_in = gold_in;
      2:       lock_in = gold_in ^ 7'h01;
      3:       lock_in = (key_out == 3'd5 || key_out == 3'd6) ? gold_in : (gold_in ^ 7'h40);
      default: lock_in = gold_in;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hand-derived sweep results per harness mode.
  function automatic exp_t expect_for(input int m);
    exp_t e;
`ifdef KEY_SWEEP_EARLY_STOP_EN
    case (m)
      0:       e = '{1'b1, 3'd0, 4'd1, 5'd0,  3'd0, 16'd33};
      1:       e = '{1'b1, 3'd0, 4'd1, 5'd0,  3'd0, 16'd33};
      2:       e = '{1'b0, 3'd0, 4'd0, 5'd16, 3'd7, 16'd257};
      default: e = '{1'b1, 3'd5, 4'd1, 5'd0,  3'd5, 16'd193};
    endcase
`else
    case (m)
      0:       e = '{1'b1, 3'd0, 4'd1, 5'd16, 3'd7, 16'd257};
      1:       e = '{1'b1, 3'd0, 4'd8, 5'd0,  3'd7, 16'd257};
      2:       e = '{1'b0, 3'd0, 4'd0, 5'd16, 3'd7, 16'd257};
      default: e = '{1'b1, 3'd5, 4'd2, 5'd16, 3'd7, 16'd257};
    endcase
`endif
    return e;
  endfunction

  // Monitor: per-key pattern sequence and end-of-sweep results.
  initial begin : monitor
    logic [35:0] prev_pat;
    logic [2:0]  prev_key;
    bit          have_prev;
    int          pidx;
    int          busy_cnt;
    exp_t        e;
    have_prev = 1'b0;
    pidx      = 0;
    busy_cnt  = 0;
    prev_pat  = 36'd0;
    prev_key  = 3'd0;
    forever begin
      @(negedge clk);
      if (rst || !busy) begin
        have_prev = 1'b0;
        busy_cnt  = 0;
      end else begin
        busy_cnt++;
        if (!done) begin
          if (!have_prev || key_out != prev_key || pat_out != prev_pat) begin
            if (!have_prev || key_out != prev_key) pidx = 0;
            else pidx++;
            if (pidx < 16) check("pattern", {28'd0, pat_out}, {28'd0, exp_pat[pidx]});
            else check("pattern_count", 64'(pidx), 64'd15);
          end
          prev_pat  = pat_out;
          prev_key  = key_out;
          have_prev = 1'b1;
        end else begin
          if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("found",      {63'd0, found},      {63'd0, e.found});
            check("found_key",  {61'd0, found_key},  {61'd0, e.fk});
            check("pass_count", {60'd0, pass_count}, {60'd0, e.pass});
            check("mm_count",   {59'd0, mm_count},   {59'd0, e.mm});
            check("key_out",    {61'd0, key_out},    {61'd0, e.key});
            check("cycles",     64'(busy_cnt),       {48'd0, e.cycles});
          end
        end
      end
    end
  end

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_sweep(input int m, input bit hold, input bit chk_clear);
    mode = m;
    sb.push_back(expect_for(m));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check("busy_first_apply", {63'd0, busy}, 64'd1);
    if (chk_clear) begin
      check("clear_found", {63'd0, found},      64'd0);
      check("clear_pass",  {60'd0, pass_count}, 64'd0);
      check("clear_mm",    {59'd0, mm_count},   64'd0);
    end
    wait_done();
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("idle_after_done", {63'd0, busy}, 64'd0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    exp_pat[0] = 36'hAAAAAAAAA;
    exp_pat[1] = 36'h555555554;
    for (int i = 2; i < 16; i++) begin
      exp_pat[i] = {exp_pat[i-1][34:0], exp_pat[i-1][35] ^ exp_pat[i-1][11]};
    end

    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pat",   {28'd0, pat_out},    64'd0);
    check("rst_key",   {61'd0, key_out},    64'd0);
    check("rst_busy",  {63'd0, busy},       64'd0);
    check("rst_done",  {63'd0, done},       64'd0);
    check("rst_found", {63'd0, found},      64'd0);
    check("rst_pass",  {60'd0, pass_count}, 64'd0);
    check("rst_mm",    {59'd0, mm_count},   64'd0);
    rst = 1'b0;

    do_sweep(0, 1'b0, 1'b0);   // correct key 0
    do_sweep(1, 1'b1, 1'b0);   // transparent lock, start held high throughout
    do_sweep(2, 1'b0, 1'b1);   // always corrupt; results cleared at start
    do_sweep(3, 1'b0, 1'b1);   // keys 5 and 6 correct

    // Reset in the middle of key 4 (always-corrupt harness reaches key 4).
    mode = 2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (key_out == 3'd4) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_key4", {63'd0, ok}, 64'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_pat",  {28'd0, pat_out},    64'd0);
    check("mid_rst_key",  {61'd0, key_out},    64'd0);
    check("mid_rst_busy", {63'd0, busy},       64'd0);
    check("mid_rst_done", {63'd0, done},       64'd0);
    check("mid_rst_fk",   {61'd0, found_key},  64'd0);
    check("mid_rst_pass", {60'd0, pass_count}, 64'd0);
    check("mid_rst_mm",   {59'd0, mm_count},   64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("post_rst_idle", {63'd0, busy}, 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
